// File: rtl/cci_host_mem_responder.sv
// Host-memory model answering CCI-P c0 line reads and c1 line writes with fixed in-order latencies.
// A backdoor port preloads and inspects lines without touching the request channels.
module cci_host_mem_responder #(
  parameter int ADDR_BITS  = 10,
  parameter int MDATA_BITS = 16,
  parameter int RD_LATENCY = 8,
  parameter int WR_LATENCY = 4,
  parameter int RDQ_DEPTH  = 16,
  parameter int AF_SLACK   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c0_req_valid,
  input  logic [41:0]           c0_req_addr,
  input  logic [MDATA_BITS-1:0] c0_req_mdata,
  output logic                  c0_almost_full,
  output logic                  c0_rsp_valid,
  output logic [511:0]          c0_rsp_data,
  output logic [MDATA_BITS-1:0] c0_rsp_mdata,
  input  logic                  c1_req_valid,
  input  logic [41:0]           c1_req_addr,
  input  logic [511:0]          c1_req_data,
  input  logic [MDATA_BITS-1:0] c1_req_mdata,
  output logic                  c1_rsp_valid,
  output logic [MDATA_BITS-1:0] c1_rsp_mdata,
  input  logic                  bd_wr_en,
  input  logic [ADDR_BITS-1:0]  bd_addr,
  input  logic [511:0]          bd_wr_data,
  output logic [511:0]          bd_rd_data,
  output logic                  err_overflow,
  output logic                  err_oob
);
  localparam int MEM_DEPTH = 2 ** ADDR_BITS;
  localparam int QW = $clog2(RDQ_DEPTH);
  localparam int QC = QW + 1;
  localparam logic [7:0]    RD_AGE_POP = 8'(RD_LATENCY - 1);
  localparam logic [QC-1:0] Q_FULL     = QC'(RDQ_DEPTH);
  localparam logic [QC-1:0] Q_AF       = QC'(RDQ_DEPTH - AF_SLACK);

  typedef struct packed {
    logic [ADDR_BITS-1:0]  idx;
    logic [MDATA_BITS-1:0] mdata;
    logic [7:0]            stamp;
  } rdq_entry_t;

  logic [511:0] mem_q [MEM_DEPTH];
  rdq_entry_t   rdq_q [RDQ_DEPTH];

  logic [QW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [QW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [QC-1:0]         count_q, count_d;
  logic [7:0]            stamp_q, stamp_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [511:0]          rsp_data_q, rsp_data_d;
  logic [MDATA_BITS-1:0] rsp_mdata_q, rsp_mdata_d;
  logic                  af_q, af_d;
  logic                  ovf_q, ovf_d;
  logic                  oob_q, oob_d;
  logic [511:0]          bd_rd_data_q, bd_rd_data_d;
  logic [WR_LATENCY-1:0] ack_vld_q, ack_vld_d;
  logic [MDATA_BITS-1:0] ack_mdata_q [WR_LATENCY];
  logic [MDATA_BITS-1:0] ack_mdata_d [WR_LATENCY];

  logic [ADDR_BITS-1:0] c1_idx;
  rdq_entry_t           head;
  logic [7:0]           head_age;
  logic                 pop;
  logic                 push;

  always_comb begin
    c1_idx   = c1_req_addr[ADDR_BITS-1:0];
    head     = rdq_q[rd_ptr_q];
    head_age = stamp_q - head.stamp;
    pop      = (count_q != '0) && (head_age == RD_AGE_POP);
    // a pop in the same cycle frees the slot a full-queue read needs
    push     = c0_req_valid && ((count_q != Q_FULL) || pop);

    wr_ptr_d = wr_ptr_q + QW'(push);
    rd_ptr_d = rd_ptr_q + QW'(pop);
    count_d  = count_q + QC'(push) - QC'(pop);
    stamp_d  = stamp_q + 8'd1;

    rsp_valid_d = pop;
    rsp_data_d  = rsp_data_q;
    rsp_mdata_d = rsp_mdata_q;
    if (pop) begin
      rsp_mdata_d = head.mdata;
      // forward same-edge writes so the response sees every commit up to the pop edge
      if (c1_req_valid && (c1_idx == head.idx)) begin
        rsp_data_d = c1_req_data;
      end else if (bd_wr_en && (bd_addr == head.idx)) begin
        rsp_data_d = bd_wr_data;
      end else begin
        rsp_data_d = mem_q[head.idx];
      end
    end

    af_d  = (count_d >= Q_AF);
    ovf_d = ovf_q | (c0_req_valid & ~push);
    oob_d = oob_q
          | (c0_req_valid && (c0_req_addr[41:ADDR_BITS] != '0))
          | (c1_req_valid && (c1_req_addr[41:ADDR_BITS] != '0));

    bd_rd_data_d = mem_q[bd_addr];

    ack_vld_d      = '0;
    ack_vld_d[0]   = c1_req_valid;
    ack_mdata_d[0] = c1_req_mdata;
    for (int i = 1; i < WR_LATENCY; i++) begin
      ack_vld_d[i]   = ack_vld_q[i-1];
      ack_mdata_d[i] = ack_mdata_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      stamp_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_mdata_q  <= '0;
      af_q         <= 1'b0;
      ovf_q        <= 1'b0;
      oob_q        <= 1'b0;
      bd_rd_data_q <= '0;
      ack_vld_q    <= '0;
      for (int i = 0; i < WR_LATENCY; i++) begin
        ack_mdata_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      stamp_q      <= stamp_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_mdata_q  <= rsp_mdata_d;
      af_q         <= af_d;
      ovf_q        <= ovf_d;
      oob_q        <= oob_d;
      bd_rd_data_q <= bd_rd_data_d;
      ack_vld_q    <= ack_vld_d;
      for (int i = 0; i < WR_LATENCY; i++) begin
        ack_mdata_q[i] <= ack_mdata_d[i];
      end
    end
  end

  // Storage arrays keep their contents across reset; the c1 write is ordered last so it wins.
  always_ff @(posedge clk) begin
    if (push) begin
      rdq_q[wr_ptr_q] <= '{idx: c0_req_addr[ADDR_BITS-1:0], mdata: c0_req_mdata, stamp: stamp_q};
    end
    if (bd_wr_en) begin
      mem_q[bd_addr] <= bd_wr_data;
    end
    if (c1_req_valid) begin
      mem_q[c1_idx] <= c1_req_data;
    end
  end

  assign c0_almost_full = af_q;
  assign c0_rsp_valid   = rsp_valid_q;
  assign c0_rsp_data    = rsp_data_q;
  assign c0_rsp_mdata   = rsp_mdata_q;
  assign c1_rsp_valid   = ack_vld_q[WR_LATENCY-1];
  assign c1_rsp_mdata   = ack_mdata_q[WR_LATENCY-1];
  assign bd_rd_data     = bd_rd_data_q;
  assign err_overflow   = ovf_q;
  assign err_oob        = oob_q;

endmodule

// File: tb/tb_cci_host_mem_responder.sv
// Bench for cci_host_mem_responder: cycle model of reads/writes plus directed latency, overflow and reset cases.
module tb_cci_host_mem_responder;
  localparam int AB  = 10;
  localparam int MB  = 16;
  localparam int RL  = 8;
  localparam int WL  = 4;
  localparam int QD  = 16;
  localparam int AFS = 4;
  localparam int SRL = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          c0_req_valid;
  logic [41:0]   c0_req_addr;
  logic [MB-1:0] c0_req_mdata;
  logic          c0_almost_full;
  logic          c0_rsp_valid;
  logic [511:0]  c0_rsp_data;
  logic [MB-1:0] c0_rsp_mdata;
  logic          c1_req_valid;
  logic [41:0]   c1_req_addr;
  logic [511:0]  c1_req_data;
  logic [MB-1:0] c1_req_mdata;
  logic          c1_rsp_valid;
  logic [MB-1:0] c1_rsp_mdata;
  logic          bd_wr_en;
  logic [AB-1:0] bd_addr;
  logic [511:0]  bd_wr_data;
  logic [511:0]  bd_rd_data;
  logic          err_overflow;
  logic          err_oob;

  logic          s_c0_req_valid;
  logic [41:0]   s_c0_req_addr;
  logic [MB-1:0] s_c0_req_mdata;
  logic          s_c0_almost_full;
  logic          s_c0_rsp_valid;
  logic [511:0]  s_c0_rsp_data;
  logic [MB-1:0] s_c0_rsp_mdata;
  logic          s_c1_rsp_valid;
  logic [MB-1:0] s_c1_rsp_mdata;
  logic [511:0]  s_bd_rd_data;
  logic          s_err_overflow;
  logic          s_err_oob;

  cci_host_mem_responder #(.ADDR_BITS(AB), .MDATA_BITS(MB), .RD_LATENCY(RL), .WR_LATENCY(WL),
                           .RDQ_DEPTH(QD), .AF_SLACK(AFS)) u_dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c0_almost_full(c0_almost_full), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .c0_rsp_mdata(c0_rsp_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data),
    .c1_req_mdata(c1_req_mdata), .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .bd_wr_en(bd_wr_en), .bd_addr(bd_addr), .bd_wr_data(bd_wr_data), .bd_rd_data(bd_rd_data),
    .err_overflow(err_overflow), .err_oob(err_oob)
  );

  cci_host_mem_responder #(.ADDR_BITS(AB), .MDATA_BITS(MB), .RD_LATENCY(SRL), .WR_LATENCY(WL),
                           .RDQ_DEPTH(QD), .AF_SLACK(AFS)) u_dut_slow (
    .clk(clk), .reset(reset),
    .c0_req_valid(s_c0_req_valid), .c0_req_addr(s_c0_req_addr), .c0_req_mdata(s_c0_req_mdata),
    .c0_almost_full(s_c0_almost_full), .c0_rsp_valid(s_c0_rsp_valid), .c0_rsp_data(s_c0_rsp_data),
    .c0_rsp_mdata(s_c0_rsp_mdata),
    .c1_req_valid(1'b0), .c1_req_addr(42'd0), .c1_req_data(512'd0), .c1_req_mdata(16'd0),
    .c1_rsp_valid(s_c1_rsp_valid), .c1_rsp_mdata(s_c1_rsp_mdata),
    .bd_wr_en(1'b0), .bd_addr(10'd0), .bd_wr_data(512'd0), .bd_rd_data(s_bd_rd_data),
    .err_overflow(s_err_overflow), .err_oob(s_err_oob)
  );

  typedef struct { int due; logic [AB-1:0] idx; logic [MB-1:0] mdata; } rd_t;
  typedef struct { int due; logic [MB-1:0] mdata; } ack_t;
  typedef struct { int cyc; logic [MB-1:0] mdata; logic [511:0] data; } rsp_t;
  typedef struct { logic [41:0] addr; logic [AB-1:0] pre_idx; logic [511:0] pre; logic [MB-1:0] mdata; } vec_t;

  rd_t          pend[$];
  ack_t         acks[$];
  logic [511:0] mmem [int];
  rsp_t         got[$];
  rsp_t         ackq[$];
  rsp_t         s_got[$];

  logic          e_rv, e_af, e_ov, e_oob, e_av;
  logic [511:0]  e_rd, e_bd;
  logic [MB-1:0] e_rm, e_am;
  bit            e_bd_known;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom();
    return d;
  endfunction

  // Reference: reads come back RL cycles after acceptance, in order, with data as of the cycle before.
  task automatic model_cycle();
    int occ;
    bit pop;
    if (reset) begin
      pend.delete();
      acks.delete();
      e_rv = 0; e_rd = '0; e_rm = '0; e_af = 0; e_ov = 0; e_oob = 0;
      e_bd = '0; e_bd_known = 1; e_av = 0; e_am = '0;
      return;
    end
    e_bd_known = mmem.exists(int'(bd_addr));
    if (e_bd_known) e_bd = mmem[int'(bd_addr)];
    if (bd_wr_en) mmem[int'(bd_addr)] = bd_wr_data;
    if (c1_req_valid) begin
      mmem[int'(c1_req_addr[AB-1:0])] = c1_req_data;
      acks.push_back('{due: cyc + WL, mdata: c1_req_mdata});
    end
    occ = pend.size();
    pop = (occ > 0) && (pend[0].due == cyc + 1);
    e_rv = pop;
    if (pop) begin
      e_rd = mmem[int'(pend[0].idx)];
      e_rm = pend[0].mdata;
      void'(pend.pop_front());
    end
    if (c0_req_valid) begin
      if (occ < QD || pop) pend.push_back('{due: cyc + RL, idx: c0_req_addr[AB-1:0], mdata: c0_req_mdata});
      else e_ov = 1;
    end
    if ((c0_req_valid && c0_req_addr[41:AB] != 0) || (c1_req_valid && c1_req_addr[41:AB] != 0)) e_oob = 1;
    e_af = (pend.size() >= QD - AFS);
    e_av = (acks.size() > 0) && (acks[0].due == cyc + 1);
    if (e_av) begin
      e_am = acks[0].mdata;
      void'(acks.pop_front());
    end
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    chk("rsp_valid", c0_rsp_valid, e_rv);
    chk("rsp_data", c0_rsp_data, e_rd);
    chk("rsp_mdata", c0_rsp_mdata, e_rm);
    chk("almost_full", c0_almost_full, e_af);
    chk("ack_valid", c1_rsp_valid, e_av);
    if (e_av) chk("ack_mdata", c1_rsp_mdata, e_am);
    if (e_bd_known) chk("bd_rd", bd_rd_data, e_bd);
    chk("err_overflow", err_overflow, e_ov);
    chk("err_oob", err_oob, e_oob);
    if (c0_rsp_valid) got.push_back('{cyc: cyc, mdata: c0_rsp_mdata, data: c0_rsp_data});
    if (c1_rsp_valid) ackq.push_back('{cyc: cyc, mdata: c1_rsp_mdata, data: '0});
    if (s_c0_rsp_valid) s_got.push_back('{cyc: cyc, mdata: s_c0_rsp_mdata, data: s_c0_rsp_data});
  endtask

  task automatic idle();
    c0_req_valid = 0; c0_req_addr = '0; c0_req_mdata = '0;
    c1_req_valid = 0; c1_req_addr = '0; c1_req_data = '0; c1_req_mdata = '0;
    bd_wr_en = 0; bd_wr_data = '0;
    s_c0_req_valid = 0; s_c0_req_addr = '0; s_c0_req_mdata = '0;
  endtask

  task automatic wait_rsp(int n, int budget);
    for (int i = 0; i < budget && got.size() < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int t0;
    tbl[0] = '{addr: 42'd5,     pre_idx: 10'd5,    pre: 512'hA5,        mdata: 16'h0011};
    tbl[1] = '{addr: 42'd0,     pre_idx: 10'd0,    pre: 512'h1234_5678, mdata: 16'hBEEF};
    tbl[2] = '{addr: 42'd1023,  pre_idx: 10'd1023, pre: {16{32'hCAFE_F00D}}, mdata: 16'hFFFF};
    tbl[3] = '{addr: 42'h405,   pre_idx: 10'd5,    pre: 512'h0F0F,      mdata: 16'h0505};

    idle();
    bd_addr = '0;
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("slow_reset_valid", s_c0_rsp_valid, 1'b0);
    chk("slow_reset_af", s_c0_almost_full, 1'b0);
    chk("slow_reset_ovf", s_err_overflow, 1'b0);

    for (int i = 0; i < 32; i++) begin
      bd_wr_en = 1; bd_addr = AB'(i); bd_wr_data = rand512();
      tick();
    end
    idle();

    // wrapped, out-of-range write lands at index 2 and flags err_oob
    chk("oob_before", err_oob, 1'b0);
    c1_req_valid = 1; c1_req_addr = (42'd1 << 10) | 42'd2; c1_req_data = 512'h55; c1_req_mdata = 16'h0002;
    tick();
    idle();
    bd_addr = 10'd2;
    tick();
    chk("oob_after", err_oob, 1'b1);
    chk("wrap_bd_rd", bd_rd_data, 512'h55);
    for (int i = 0; i < 6; i++) tick();

    for (int v = 0; v < 4; v++) begin
      bd_wr_en = 1; bd_addr = tbl[v].pre_idx; bd_wr_data = tbl[v].pre;
      tick();
      idle();
      got.delete();
      t0 = cyc;
      c0_req_valid = 1; c0_req_addr = tbl[v].addr; c0_req_mdata = tbl[v].mdata;
      tick();
      idle();
      wait_rsp(1, 20);
      chk("tbl_rsp_seen", got.size(), 1);
      if (got.size() > 0) begin
        chk("tbl_latency", got[0].cyc - t0, RL);
        chk("tbl_data", got[0].data, tbl[v].pre);
        chk("tbl_mdata", got[0].mdata, tbl[v].mdata);
      end
    end

    got.delete();
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      c0_req_valid = 1; c0_req_addr = 42'(i); c0_req_mdata = MB'(i);
      tick();
    end
    idle();
    wait_rsp(16, 30);
    chk("b2b_count", got.size(), 16);
    for (int i = 0; i < got.size(); i++) begin
      chk("b2b_mdata", got[i].mdata, MB'(i));
      chk("b2b_cycle", got[i].cyc, t0 + RL + i);
    end
    chk("b2b_no_ovf", err_overflow, 1'b0);

    got.delete(); ackq.delete();
    t0 = cyc;
    c1_req_valid = 1; c1_req_addr = 42'd7; c1_req_data = 512'hDEAD; c1_req_mdata = 16'd3;
    c0_req_valid = 1; c0_req_addr = 42'd7; c0_req_mdata = 16'h0077;
    tick();
    idle();
    wait_rsp(1, 20);
    chk("wr_ack_seen", ackq.size(), 1);
    if (ackq.size() > 0) begin
      chk("wr_ack_cycle", ackq[0].cyc - t0, WL);
      chk("wr_ack_mdata", ackq[0].mdata, 16'd3);
    end
    chk("wrrd_seen", got.size(), 1);
    if (got.size() > 0) begin
      chk("wrrd_cycle", got[0].cyc - t0, RL);
      chk("wrrd_data", got[0].data, 512'hDEAD);
    end

    // a c1 write on the pop edge must be visible in that response
    got.delete();
    t0 = cyc;
    c0_req_valid = 1; c0_req_addr = 42'd9; c0_req_mdata = 16'h0099;
    tick();
    idle();
    for (int i = 0; i < RL - 2; i++) tick();
    c1_req_valid = 1; c1_req_addr = 42'd9; c1_req_data = 512'h1234; c1_req_mdata = 16'h0009;
    tick();
    idle();
    wait_rsp(1, 20);
    chk("fwd_seen", got.size(), 1);
    if (got.size() > 0) begin
      chk("fwd_cycle", got[0].cyc - t0, RL);
      chk("fwd_data", got[0].data, 512'h1234);
    end

    s_got.delete();
    t0 = cyc;
    for (int k = 1; k <= 17; k++) begin
      s_c0_req_valid = 1; s_c0_req_addr = 42'(k - 1); s_c0_req_mdata = MB'(k - 1);
      tick();
      chk("slow_af", s_c0_almost_full, (k >= QD - AFS) ? 1'b1 : 1'b0);
    end
    idle();
    tick();
    chk("slow_ovf", s_err_overflow, 1'b1);
    for (int i = 0; i < 300 && s_got.size() < 16; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    chk("slow_count", s_got.size(), 16);
    if (s_got.size() > 0) chk("slow_latency", s_got[0].cyc - t0, SRL);
    for (int i = 0; i < s_got.size(); i++) chk("slow_mdata", s_got[i].mdata, MB'(i));

    for (int i = 0; i < 500; i++) begin
      idle();
      if (!c0_almost_full && ($urandom_range(0, 99) < 60)) begin
        c0_req_valid = 1;
        c0_req_addr = 42'($urandom_range(0, 31));
        if ($urandom_range(0, 31) == 0) c0_req_addr[20] = 1'b1;
        c0_req_mdata = MB'($urandom());
      end
      if ($urandom_range(0, 99) < 40) begin
        c1_req_valid = 1;
        c1_req_addr = 42'($urandom_range(0, 31));
        c1_req_data = rand512();
        c1_req_mdata = MB'($urandom());
      end else if ($urandom_range(0, 99) < 30) begin
        bd_wr_en = 1;
        bd_wr_data = rand512();
      end
      bd_addr = AB'($urandom_range(0, 31));
      tick();
    end
    idle();
    for (int i = 0; i < 12; i++) tick();

    c1_req_valid = 1; c1_req_addr = 42'd20; c1_req_data = 512'hC0FFEE; c1_req_mdata = 16'd5;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      c0_req_valid = 1; c0_req_addr = 42'(i); c0_req_mdata = MB'(16'h100 + i);
      tick();
    end
    idle();
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    got.delete(); ackq.delete();
    for (int i = 0; i < 20; i++) tick();
    chk("rst_no_rsp", got.size(), 0);
    chk("rst_af", c0_almost_full, 1'b0);
    chk("rst_ovf", err_overflow, 1'b0);
    chk("rst_oob", err_oob, 1'b0);
    bd_addr = 10'd20;
    tick();
    chk("rst_mem_kept", bd_rd_data, 512'hC0FFEE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
